// File: rtl/dram_region_loader_pkg.sv
// Shared definitions for the DRAM region loader.
//   state_e      : FSM state encodings (also exported on state_o)
//   slice_lo     : low bit of element 'idx' in a flattened per-region bus
//   beats_eff    : beats-per-word with a programmed 0 read as 1
package dram_region_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_FETCH  = 3'd2,
        ST_WRITE  = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

    function automatic logic [31:0] beats_eff(input logic [31:0] beats);
        return (beats == 32'd0) ? 32'd1 : beats;
    endfunction

endpackage

// File: rtl/dram_region_loader_if.sv
// Bus bundle between the loader, the DRAM read port and the destination buffers.
//   dram_rd_req / dram_rd_addr / dram_rd_ack : read request handshake (req held until ack)
//   dst_wr_en / dst_wr_addr / dst_partial / dst_region : destination write strobe and tags
// master = loader side, slave = memory / buffer side.
interface dram_region_loader_if #(
    parameter int DRAM_ADDR_WIDTH = 18,
    parameter int DST_ADDR_WIDTH  = 16,
    parameter int REG_IDX_WIDTH   = 2
);
    logic                       dram_rd_req;
    logic [DRAM_ADDR_WIDTH-1:0] dram_rd_addr;
    logic                       dram_rd_ack;
    logic                       dst_wr_en;
    logic [DST_ADDR_WIDTH-1:0]  dst_wr_addr;
    logic                       dst_partial;
    logic [REG_IDX_WIDTH-1:0]   dst_region;

    modport master (
        output dram_rd_req,
        output dram_rd_addr,
        input  dram_rd_ack,
        output dst_wr_en,
        output dst_wr_addr,
        output dst_partial,
        output dst_region
    );

    modport slave (
        input  dram_rd_req,
        input  dram_rd_addr,
        output dram_rd_ack,
        input  dst_wr_en,
        input  dst_wr_addr,
        input  dst_partial,
        input  dst_region
    );
endinterface

// File: rtl/dram_region_loader_region_addr_gen.sv
// Read address generator for the region currently being loaded.
//   clr_i          : restart the offset at 0 (new region)
//   inc_i          : advance the offset by one (beat accepted)
//   start_addr_i   : start address of the selected region
//   finish_addr_i  : inclusive last address of the selected region
//   addr_o         : address for the offset value taking effect at the next edge
//   last_o         : addr_o is the region's finish address
// Looking one edge ahead lets the FSM register the request address.
module dram_region_loader_region_addr_gen #(
    parameter int ADDR_W = 18
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              inc_i,
    input  logic [ADDR_W-1:0] start_addr_i,
    input  logic [ADDR_W-1:0] finish_addr_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);
    logic [ADDR_W-1:0] offset_q;
    logic [ADDR_W-1:0] offset_d;

    always_comb begin
        offset_d = offset_q;
        if (clr_i) begin
            offset_d = '0;
        end else if (inc_i) begin
            offset_d = offset_q + ADDR_W'(1);
        end
    end

    assign addr_o = start_addr_i + offset_d;
    assign last_o = (addr_o == finish_addr_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            offset_q <= '0;
        end else begin
            offset_q <= offset_d;
        end
    end
endmodule

// File: rtl/dram_region_loader.sv
// Streams up to N_REGIONS contiguous DRAM regions, in index order, into on-chip buffers.
//   clk_i, weight_wr_addr_rst   : clock, async active-high reset
//   start_i                     : start pulse (honoured in IDLE / DONE)
//   region_en_i                 : per-region enable, sampled at start
//   region_start_addr_i         : flattened per-region start addresses
//   region_finish_addr_i        : flattened per-region inclusive finish addresses
//   region_beats_i              : flattened per-region beats per destination word (0 = 1)
//   bus                         : DRAM read handshake + destination write port
//   region_done_o               : sticky per-region completion flags
//   busy_o / done_o / state_o   : status
//
// state  | meaning
// IDLE   | waiting for start
// SELECT | pick the next enabled region, skip empty ones
// FETCH  | request one DRAM beat, wait for ack
// WRITE  | one-cycle destination write strobe
// DONE   | all enabled regions loaded, waiting for restart
module dram_region_loader
    import dram_region_loader_pkg::*;
#(
    parameter int DRAM_ADDR_WIDTH = 18,
    parameter int DST_ADDR_WIDTH  = 16,
    parameter int N_REGIONS       = 4,
    parameter int REG_IDX_WIDTH   = 2,
    parameter int BEAT_CNT_WIDTH  = 4
) (
    input  logic                                 clk_i,
    input  logic                                 weight_wr_addr_rst,
    input  logic                                 start_i,
    input  logic [N_REGIONS-1:0]                 region_en_i,
    input  logic [N_REGIONS*DRAM_ADDR_WIDTH-1:0] region_start_addr_i,
    input  logic [N_REGIONS*DRAM_ADDR_WIDTH-1:0] region_finish_addr_i,
    input  logic [N_REGIONS*BEAT_CNT_WIDTH-1:0]  region_beats_i,
    dram_region_loader_if.master                 bus,
    output logic [N_REGIONS-1:0]                 region_done_o,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic [2:0]                           state_o
);
    // One extra bit so the scan pointer can step past the last region.
    localparam int SCAN_W = REG_IDX_WIDTH + 1;

    state_e                      state_q, state_d;
    logic [SCAN_W-1:0]           idx_q, idx_d;
    logic [N_REGIONS-1:0]        en_q, en_d;
    logic [N_REGIONS-1:0]        region_done_q, region_done_d;
    logic [BEAT_CNT_WIDTH-1:0]   beat_q, beat_d;
    logic [DST_ADDR_WIDTH-1:0]   dst_addr_q, dst_addr_d;
    logic [DRAM_ADDR_WIDTH-1:0]  rd_addr_q, rd_addr_d;
    logic                        last_q, last_d;
    logic                        partial_q, partial_d;
    logic [REG_IDX_WIDTH-1:0]    region_q, region_d;
    logic                        req_q, req_d;
    logic                        wr_en_q, wr_en_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;

    logic                        sel_found;
    logic [REG_IDX_WIDTH-1:0]    sel_idx;
    logic [REG_IDX_WIDTH-1:0]    cur_idx;
    logic [DRAM_ADDR_WIDTH-1:0]  start_sel;
    logic [DRAM_ADDR_WIDTH-1:0]  finish_sel;
    logic [BEAT_CNT_WIDTH-1:0]   beats_raw;
    logic [BEAT_CNT_WIDTH-1:0]   beats_sel;
    logic                        sel_empty;
    logic                        beat_last;
    logic                        gen_clr;
    logic                        gen_inc;
    logic [DRAM_ADDR_WIDTH-1:0]  gen_addr;
    logic                        gen_last;

    // Lowest enabled region at or above the scan pointer.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < N_REGIONS; i++) begin
            if (!sel_found && en_q[i] && (SCAN_W'(i) >= idx_q)) begin
                sel_found = 1'b1;
                sel_idx   = REG_IDX_WIDTH'(i);
            end
        end
    end

    // While selecting, the candidate region drives the mux; afterwards the owning region does.
    assign cur_idx    = (state_q == ST_SELECT) ? sel_idx : region_q;
    assign start_sel  = region_start_addr_i[slice_lo(32'(cur_idx), DRAM_ADDR_WIDTH) +: DRAM_ADDR_WIDTH];
    assign finish_sel = region_finish_addr_i[slice_lo(32'(cur_idx), DRAM_ADDR_WIDTH) +: DRAM_ADDR_WIDTH];
    assign beats_raw  = region_beats_i[slice_lo(32'(cur_idx), BEAT_CNT_WIDTH) +: BEAT_CNT_WIDTH];
    assign beats_sel  = BEAT_CNT_WIDTH'(beats_eff(32'(beats_raw)));
    assign sel_empty  = (finish_sel < start_sel);
    assign beat_last  = (beat_q == (beats_sel - BEAT_CNT_WIDTH'(1)));

    assign gen_clr = (state_q == ST_SELECT) && sel_found && !sel_empty;
    assign gen_inc = (state_q == ST_FETCH) && bus.dram_rd_ack;

    dram_region_loader_region_addr_gen #(
        .ADDR_W (DRAM_ADDR_WIDTH)
    ) u_region_addr_gen (
        .clk_i         (clk_i),
        .rst_i         (weight_wr_addr_rst),
        .clr_i         (gen_clr),
        .inc_i         (gen_inc),
        .start_addr_i  (start_sel),
        .finish_addr_i (finish_sel),
        .addr_o        (gen_addr),
        .last_o        (gen_last)
    );

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        en_d          = en_q;
        region_done_d = region_done_q;
        beat_d        = beat_q;
        dst_addr_d    = dst_addr_q;
        rd_addr_d     = rd_addr_q;
        last_d        = last_q;
        partial_d     = 1'b0;
        region_d      = region_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    en_d          = region_en_i;
                    region_done_d = '0;
                    idx_d         = '0;
                    state_d       = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (!sel_found) begin
                    state_d = ST_DONE;
                end else if (sel_empty) begin
                    region_done_d[sel_idx] = 1'b1;
                    idx_d                  = SCAN_W'(sel_idx) + SCAN_W'(1);
                end else begin
                    region_d   = sel_idx;
                    idx_d      = SCAN_W'(sel_idx);
                    beat_d     = '0;
                    dst_addr_d = '0;
                    state_d    = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (bus.dram_rd_ack) begin
                    if (last_q || beat_last) begin
                        // A word cut short by the region end is flagged partial.
                        partial_d = !beat_last;
                        state_d   = ST_WRITE;
                    end else begin
                        beat_d = beat_q + BEAT_CNT_WIDTH'(1);
                    end
                end
            end
            ST_WRITE: begin
                // Region ends on its finish address or when the destination counter saturates.
                if (last_q || (dst_addr_q == {DST_ADDR_WIDTH{1'b1}})) begin
                    region_done_d[region_q] = 1'b1;
                    idx_d                   = SCAN_W'(region_q) + SCAN_W'(1);
                    state_d                 = ST_SELECT;
                end else begin
                    dst_addr_d = dst_addr_q + DST_ADDR_WIDTH'(1);
                    beat_d     = '0;
                    state_d    = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Address only moves when a FETCH cycle follows, so it is stable while req is high.
        if (state_d == ST_FETCH) begin
            rd_addr_d = gen_addr;
            last_d    = gen_last;
        end

        req_d   = (state_d == ST_FETCH);
        wr_en_d = (state_d == ST_WRITE);
        busy_d  = (state_d == ST_SELECT) || (state_d == ST_FETCH) || (state_d == ST_WRITE);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk_i or posedge weight_wr_addr_rst) begin
        if (weight_wr_addr_rst) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            en_q          <= '0;
            region_done_q <= '0;
            beat_q        <= '0;
            dst_addr_q    <= '0;
            rd_addr_q     <= '0;
            last_q        <= 1'b0;
            partial_q     <= 1'b0;
            region_q      <= '0;
            req_q         <= 1'b0;
            wr_en_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            en_q          <= en_d;
            region_done_q <= region_done_d;
            beat_q        <= beat_d;
            dst_addr_q    <= dst_addr_d;
            rd_addr_q     <= rd_addr_d;
            last_q        <= last_d;
            partial_q     <= partial_d;
            region_q      <= region_d;
            req_q         <= req_d;
            wr_en_q       <= wr_en_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign bus.dram_rd_req  = req_q;
    assign bus.dram_rd_addr = rd_addr_q;
    assign bus.dst_wr_en    = wr_en_q;
    assign bus.dst_wr_addr  = dst_addr_q;
    assign bus.dst_partial  = partial_q;
    assign bus.dst_region   = region_q;
    assign region_done_o    = region_done_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign state_o          = state_q;

endmodule

// File: tb/tb_dram_region_loader.sv
module tb_dram_region_loader;
    localparam int NR = 4;
    localparam int AW = 18;
    localparam int DW = 2;
    localparam int IW = 2;
    localparam int BW = 4;

    typedef struct packed {
        logic [IW-1:0] rgn;
        logic [DW-1:0] dst;
        logic          part;
    } wr_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [NR-1:0]    en_in;
    logic [NR*AW-1:0] st_in;
    logic [NR*AW-1:0] fin_in;
    logic [NR*BW-1:0] bt_in;
    logic [NR-1:0]    rdone;
    logic             busy;
    logic             done;
    logic [2:0]       state;

    dram_region_loader_if #(.DRAM_ADDR_WIDTH(AW), .DST_ADDR_WIDTH(DW), .REG_IDX_WIDTH(IW)) bus();

    dram_region_loader #(
        .DRAM_ADDR_WIDTH (AW),
        .DST_ADDR_WIDTH  (DW),
        .N_REGIONS       (NR),
        .REG_IDX_WIDTH   (IW),
        .BEAT_CNT_WIDTH  (BW)
    ) dut (
        .clk_i                (clk),
        .weight_wr_addr_rst   (rst),
        .start_i              (start),
        .region_en_i          (en_in),
        .region_start_addr_i  (st_in),
        .region_finish_addr_i (fin_in),
        .region_beats_i       (bt_in),
        .bus                  (bus),
        .region_done_o        (rdone),
        .busy_o               (busy),
        .done_o               (done),
        .state_o              (state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [AW-1:0] q_rd[$];
    wr_t           q_wr[$];
    int            q_dn[$];
    logic [NR-1:0] exp_mask;

    logic [NR-1:0] c_en;
    int unsigned   c_st[NR];
    int unsigned   c_fin[NR];
    int unsigned   c_bt[NR];

    bit            mon_on = 1'b0;
    bit            hs_flag = 1'b0;
    int            gap_max = 0;
    int            gap_left = 0;
    int            wr_tot[NR] = '{default: 0};
    int            wr_base[NR];
    logic          last_part[NR];
    logic [DW-1:0] last_dst[NR];
    logic [NR-1:0] prev_done = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string nm);
        chk(nm, {bus.dram_rd_req, bus.dram_rd_addr, bus.dst_wr_en, bus.dst_wr_addr,
                 bus.dst_partial, bus.dst_region, rdone, busy, done, state}, 64'd0);
    endtask

    // Reference model: each enabled region is cut into words of 'beats' consecutive
    // addresses; the destination index counts words and the region stops once the
    // last destination word has been written.
    task automatic build_expect();
        wr_t w;
        q_rd.delete();
        q_wr.delete();
        q_dn.delete();
        exp_mask = '0;
        for (int r = 0; r < NR; r++) begin
            int unsigned b, n, a, len, d;
            if (c_en[r]) begin
                exp_mask[r] = 1'b1;
                q_dn.push_back(r);
                if (c_fin[r] >= c_st[r]) begin
                    b = (c_bt[r] == 0) ? 1 : c_bt[r];
                    n = c_fin[r] - c_st[r] + 1;
                    a = 0;
                    d = 0;
                    while (a < n) begin
                        len = ((n - a) < b) ? (n - a) : b;
                        for (int k = 0; k < int'(len); k++) q_rd.push_back(AW'(c_st[r] + a + k));
                        a += len;
                        w.rgn  = IW'(r);
                        w.dst  = DW'(d);
                        w.part = (len < b);
                        q_wr.push_back(w);
                        if (d == (1 << DW) - 1) break;
                        d++;
                    end
                end
            end
        end
    endtask

    task automatic apply_cfg();
        en_in = c_en;
        for (int r = 0; r < NR; r++) begin
            st_in[r*AW +: AW]  = AW'(c_st[r]);
            fin_in[r*AW +: AW] = AW'(c_fin[r]);
            bt_in[r*BW +: BW]  = BW'(c_bt[r]);
        end
    endtask

    task automatic set_region(input int r, input int unsigned s, input int unsigned f, input int unsigned b);
        c_st[r]  = s;
        c_fin[r] = f;
        c_bt[r]  = b;
    endtask

    task automatic do_reset();
        mon_on = 1'b0;
        rst = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        q_rd.delete();
        q_wr.delete();
        q_dn.delete();
        @(negedge clk);
        rst = 1'b0;
        mon_on = 1'b1;
    endtask

    task automatic run_cfg(input int gmax, input bit poke);
        int cyc;
        apply_cfg();
        gap_max = gmax;
        build_expect();
        for (int r = 0; r < NR; r++) wr_base[r] = wr_tot[r];
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("flags_clear_on_start", rdone, 0);
        chk("busy_after_start", busy, 1);
        if (poke) begin
            repeat (4) @(posedge clk);
            #1;
            chk("busy_at_poke", busy, 1);
            start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        cyc = 0;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        #1;
        chk("done_reached", done, 1);
        chk("done_mask", rdone, exp_mask);
        chk("reads_left", q_rd.size(), 0);
        chk("writes_left", q_wr.size(), 0);
        chk("flags_left", q_dn.size(), 0);
        chk("busy_in_done", busy, 0);
        chk("state_done", state, 3'd4);
        if (!done) do_reset();
    endtask

    function automatic int wr_cnt(input int r);
        return wr_tot[r] - wr_base[r];
    endfunction

    // Monitor / scoreboard: compares DUT activity against the queued expectations.
    always @(negedge clk) begin
        logic [NR-1:0] rose, exp_rose;
        wr_t act, e;
        hs_flag = 1'b0;
        if (mon_on && !rst) begin
            if (bus.dram_rd_req) begin
                if (q_rd.size() == 0) begin
                    chk("read_unexpected", 1, 0);
                end else begin
                    chk("read_addr", bus.dram_rd_addr, q_rd[0]);
                    if (bus.dram_rd_ack) begin
                        void'(q_rd.pop_front());
                        hs_flag = 1'b1;
                    end
                end
            end
            if (bus.dst_wr_en) begin
                act.rgn  = bus.dst_region;
                act.dst  = bus.dst_wr_addr;
                act.part = bus.dst_partial;
                if (q_wr.size() == 0) begin
                    chk("write_unexpected", 1, 0);
                end else begin
                    e = q_wr.pop_front();
                    chk("write_entry", 64'(act), 64'(e));
                end
                wr_tot[bus.dst_region]++;
                last_part[bus.dst_region] = bus.dst_partial;
                last_dst[bus.dst_region]  = bus.dst_wr_addr;
            end
            rose = rdone & ~prev_done;
            if (rose != '0) begin
                if (q_dn.size() == 0) begin
                    chk("flag_unexpected", 1, 0);
                end else begin
                    exp_rose = NR'(1) << q_dn.pop_front();
                    chk("flag_order", rose, exp_rose);
                end
            end
        end
        prev_done = rdone;
    end

    // Ack driver: after each accepted beat, withhold ack for 0..gap_max cycles.
    initial begin
        bus.dram_rd_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (hs_flag && gap_max > 0) gap_left = $urandom_range(0, gap_max);
            if (gap_left > 0) begin
                bus.dram_rd_ack = 1'b0;
                gap_left--;
            end else begin
                bus.dram_rd_ack = 1'b1;
            end
        end
    end

    initial begin
        int cyc;
        bit hit;
        en_in  = '0;
        st_in  = '0;
        fin_in = '0;
        bt_in  = '0;
        for (int r = 0; r < NR; r++) set_region(r, 0, 0, 1);
        c_en = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset_outputs");
        @(negedge clk);
        rst = 1'b0;
        mon_on = 1'b1;
        #1;
        chk("idle_state", state, 0);

        // Reset while fetching address 0x105
        c_en = 4'b0001;
        set_region(0, 32'h100, 32'h10F, 15);
        apply_cfg();
        gap_max = 0;
        build_expect();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        hit = 1'b0;
        cyc = 0;
        while (!hit && cyc < 200) begin
            @(posedge clk);
            #2;
            if (bus.dram_rd_req && bus.dram_rd_addr == 18'h105) hit = 1'b1;
            cyc++;
        end
        chk("reach_addr_105", hit, 1);
        mon_on = 1'b0;
        rst = 1'b1;
        #1;
        chk_outputs_zero("midfetch_reset_outputs");
        @(posedge clk);
        #1;
        chk_outputs_zero("midfetch_reset_held");
        q_rd.delete();
        q_wr.delete();
        q_dn.delete();
        @(negedge clk);
        rst = 1'b0;
        mon_on = 1'b1;

        // All four regions, sizes 2/4/3/5, beats 1/2/1/5, start poked while busy
        c_en = 4'b1111;
        set_region(0, 32'h00010, 32'h00011, 1);
        set_region(1, 32'h00200, 32'h00203, 2);
        set_region(2, 32'h3FFF0, 32'h3FFF2, 1);
        set_region(3, 32'h12345, 32'h12349, 5);
        run_cfg(0, 1'b1);
        chk("wr_count_r0", wr_cnt(0), 2);
        chk("wr_count_r1", wr_cnt(1), 2);
        chk("wr_count_r2", wr_cnt(2), 3);
        chk("wr_count_r3", wr_cnt(3), 1);

        // Restart from DONE: identical rerun
        run_cfg(0, 1'b0);
        chk("rerun_wr_r1", wr_cnt(1), 2);
        chk("rerun_wr_r3", wr_cnt(3), 1);

        // Same config with random ack gaps
        run_cfg(7, 1'b0);
        chk("stall_wr_r0", wr_cnt(0), 2);
        chk("stall_wr_r2", wr_cnt(2), 3);

        // Regions 1 and 3 disabled
        c_en = 4'b0101;
        run_cfg(0, 1'b0);
        chk("en0101_mask", rdone, 4'b0101);
        chk("en0101_wr_r1", wr_cnt(1), 0);

        // Region 2 with finish < start
        c_en = 4'b1111;
        set_region(2, 32'h3FFF0, 32'h3FFEF, 1);
        run_cfg(0, 1'b0);
        chk("empty_r2_writes", wr_cnt(2), 0);

        // Beats 4, 6 addresses: second write partial
        c_en = 4'b0001;
        set_region(0, 32'h00400, 32'h00405, 4);
        run_cfg(0, 1'b0);
        chk("partial_wr_count", wr_cnt(0), 2);
        chk("partial_last", last_part[0], 1);

        // 10 addresses, beats 1, 2-bit destination: saturates after dst 3
        set_region(0, 32'h00020, 32'h00029, 1);
        run_cfg(3, 1'b0);
        chk("sat_wr_count", wr_cnt(0), 4);
        chk("sat_last_dst", last_dst[0], 3);

        // Randomised configurations
        for (int t = 0; t < 12; t++) begin
            c_en = NR'($urandom);
            for (int r = 0; r < NR; r++) begin
                int unsigned s, sz;
                s  = $urandom_range(1, (1 << AW) - 14);
                sz = $urandom_range(0, 12);
                if ($urandom_range(0, 5) == 0) set_region(r, s, s - 1, $urandom_range(0, 15));
                else set_region(r, s, s + sz, $urandom_range(0, 15));
            end
            run_cfg($urandom_range(0, 7), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
